// File: rtl/wave_meas.sv
// Sample-stream meter: period, per-period max/min and peak-to-peak via hysteretic rising crossings.
// Latency: results and meas_valid registered, visible the cycle after the crossing sample is accepted.
// Backpressure: none; samples qualified by data_valid, invalid cycles still advance the period counter.
module wave_meas #(
    parameter int               MID     = 128,
    parameter int               HYST    = 8,
    parameter int               CNT_W   = 24,
    parameter logic [CNT_W-1:0] TIMEOUT = 24'd5_000_000
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    output logic [CNT_W-1:0] period,
    output logic [7:0]       vmax,
    output logic [7:0]       vmin,
    output logic [7:0]       vpp,
    output logic             meas_valid,
    output logic             no_signal
);

    // Hysteresis band: a sample must drop below LO before a sample at or
    // above HI counts as a rising crossing.
    localparam logic [7:0] LO = 8'(MID - HYST);
    localparam logic [7:0] HI = 8'(MID + HYST);

    localparam logic [1:0] ARM     = 2'd0;  // waiting for a low sample
    localparam logic [1:0] ARM_HI  = 2'd1;  // low seen, waiting for first crossing
    localparam logic [1:0] MEAS_LO = 2'd2;  // measuring, waiting for low half
    localparam logic [1:0] MEAS_HI = 2'd3;  // measuring, waiting for next crossing

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       run_max;
    logic [7:0]       run_min;

    logic is_low;
    logic is_high;
    logic timeout;
    logic first_cross;
    logic crossing;
    logic track;

    assign is_low  = data_valid && (data_in < LO);
    assign is_high = data_valid && (data_in >= HI);

    // Timeout wins over any crossing arriving in the same cycle.
    assign timeout     = (cnt >= TIMEOUT);
    assign first_cross = !timeout && (state == ARM_HI) && is_high;
    assign crossing    = !timeout && (state == MEAS_HI) && is_high;

    // The crossing sample itself belongs to the next window, so it is
    // excluded from tracking in MEAS_HI and used as the seed instead.
    assign track = !timeout && data_valid &&
                   ((state == MEAS_LO) || ((state == MEAS_HI) && !is_high));

    // Crossing FSM and free-running period counter.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= ARM;
            cnt   <= '0;
        end else if (timeout) begin
            state <= ARM;
            cnt   <= '0;
        end else if (first_cross || crossing) begin
            state <= MEAS_LO;
            cnt   <= CNT_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
            case (state)
                ARM:     if (is_low) state <= ARM_HI;
                MEAS_LO: if (is_low) state <= MEAS_HI;
                default: state <= state;
            endcase
        end
    end

    // Running extremes over the current window, reseeded at every crossing.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            run_max <= 8'd0;
            run_min <= 8'd255;
        end else if (first_cross || crossing) begin
            run_max <= data_in;
            run_min <= data_in;
        end else if (track) begin
            if (data_in > run_max) run_max <= data_in;
            if (data_in < run_min) run_min <= data_in;
        end
    end

    // Result registers: updated only on a completed period, held across timeouts.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            period     <= '0;
            vmax       <= 8'd0;
            vmin       <= 8'd0;
            vpp        <= 8'd0;
            meas_valid <= 1'b0;
            no_signal  <= 1'b0;
        end else begin
            meas_valid <= crossing;
            if (timeout) begin
                no_signal <= 1'b1;
            end else if (crossing) begin
                period    <= cnt;
                vmax      <= run_max;
                vmin      <= run_min;
                vpp       <= run_max - run_min;
                no_signal <= 1'b0;
            end
        end
    end

endmodule
